// File: rtl/piano_pkg.sv
// Shared definitions for the piano audio path: note/octave codes, the
// middle-octave pitch table and the tone generator state encoding.
package piano_pkg;

    typedef logic [3:0] note_t;
    typedef logic [1:0] oct_t;

    localparam note_t NOTE_REST = 4'd0;
    localparam note_t NOTE_C    = 4'd1;
    localparam note_t NOTE_D    = 4'd2;
    localparam note_t NOTE_E    = 4'd3;
    localparam note_t NOTE_F    = 4'd4;
    localparam note_t NOTE_G    = 4'd5;
    localparam note_t NOTE_A    = 4'd6;
    localparam note_t NOTE_B    = 4'd7;

    // Code 2'b11 is not named; it plays as the middle octave.
    localparam oct_t OCT_LOW  = 2'b00;
    localparam oct_t OCT_MID  = 2'b01;
    localparam oct_t OCT_HIGH = 2'b10;

    localparam int NUM_NOTES = 7;

    // Middle-octave pitches C4..B4 in centihertz.
    localparam int unsigned FREQ_CHZ [NUM_NOTES] =
        '{26163, 29366, 32963, 34923, 39200, 44000, 49388};

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        TONE   = 2'd1,
        GAP    = 2'd2
    } tone_state_t;

    // Codes 1..7 are playable notes; 0 and 8..15 are all rests.
    function automatic logic is_note(input note_t n);
        return (n >= NOTE_C) && (n <= NOTE_B);
    endfunction

endpackage

// File: rtl/tone_generator_if.sv
// Note request / audio status bundle between the mode controller (master)
// and the tone generator (slave).
interface tone_generator_if
    import piano_pkg::*;
;
    logic        enable;
    note_t       note_in;
    oct_t        octave_in;
    logic        speaker;
    logic        amp_sd;
    note_t       playing_note;
    logic        busy;

    modport master (
        output enable, note_in, octave_in,
        input  speaker, amp_sd, playing_note, busy
    );

    modport slave (
        input  enable, note_in, octave_in,
        output speaker, amp_sd, playing_note, busy
    );
endinterface

// File: rtl/tone_period_lut.sv
// Maps a note/octave pair to the square-wave half-period in clk cycles.
// All table entries are elaboration-time constants; no divider is built.
module tone_period_lut
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  note_t       note,
    input  oct_t        octave,
    output logic [19:0] half,
    output logic        valid
);

    logic [19:0] half_tab [NUM_NOTES];

    // half = CLK_HZ / (2 * f), with f in centihertz -> CLK_HZ*50 / f_chz.
    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_half
        localparam logic [19:0] HALF_MID =
            20'((64'(CLK_HZ) * 64'd50) / 64'(FREQ_CHZ[i]));
        assign half_tab[i] = HALF_MID;
    end

    logic [19:0] base;

    // Select the middle-octave entry, then scale by octave.
    always_comb begin
        base  = '0;
        valid = is_note(note);
        case (note)
            NOTE_C:  base = half_tab[0];
            NOTE_D:  base = half_tab[1];
            NOTE_E:  base = half_tab[2];
            NOTE_F:  base = half_tab[3];
            NOTE_G:  base = half_tab[4];
            NOTE_A:  base = half_tab[5];
            NOTE_B:  base = half_tab[6];
            default: base = '0;
        endcase
        case (octave)
            OCT_LOW:  half = {base[18:0], 1'b0};
            OCT_HIGH: half = {1'b0, base[19:1]};
            default:  half = base;
        endcase
    end

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator: registers the requested note, plays it at its
// pitch, only changes pitch at half-period boundaries and inserts a silent
// gap between two distinct notes.
module tone_generator
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned GAP_CYCLES = 2_000_000
) (
    input  logic             clk,
    input  logic             reset,
    tone_generator_if.slave  bus
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    // Request register; the FSM only ever looks at these.
    note_t       req_note;
    oct_t        req_oct;
    logic        req_en;

    logic [19:0] req_half;
    logic        req_valid;

    tone_state_t state;
    logic [19:0] cnt;
    logic [19:0] half;
    logic [GW-1:0] gcnt;
    logic        phase;
    oct_t        cur_oct;
    note_t       playing_note;
    logic        amp_sd;
    logic        busy;

    tone_period_lut #(.CLK_HZ(CLK_HZ)) u_lut (
        .note   (req_note),
        .octave (req_oct),
        .half   (req_half),
        .valid  (req_valid)
    );

    // Capture the controller's request every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_note <= NOTE_REST;
            req_oct  <= OCT_MID;
            req_en   <= 1'b0;
        end else begin
            req_note <= bus.note_in;
            req_oct  <= bus.octave_in;
            req_en   <= bus.enable;
        end
    end

    // Playback FSM; outputs are registered alongside the state. phase is
    // held at 0 outside TONE, so it drives the speaker directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SILENT;
            cnt          <= '0;
            half         <= '0;
            gcnt         <= '0;
            phase        <= 1'b0;
            cur_oct      <= OCT_MID;
            playing_note <= NOTE_REST;
            amp_sd       <= 1'b0;
            busy         <= 1'b0;
        end else if (!req_en) begin
            // Mute wins immediately, no boundary wait.
            state        <= SILENT;
            cnt          <= '0;
            gcnt         <= '0;
            phase        <= 1'b0;
            playing_note <= NOTE_REST;
            amp_sd       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                SILENT: begin
                    if (req_valid) begin
                        state        <= TONE;
                        half         <= req_half;
                        cnt          <= '0;
                        phase        <= 1'b1;
                        cur_oct      <= req_oct;
                        playing_note <= req_note;
                        amp_sd       <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                TONE: begin
                    if (cnt == half - 20'd1) begin
                        // Half-period boundary: the only place pitch may change.
                        cnt <= '0;
                        if (req_valid && req_note == playing_note && req_oct == cur_oct) begin
                            phase <= ~phase;
                        end else if (!req_valid) begin
                            state        <= SILENT;
                            phase        <= 1'b0;
                            playing_note <= NOTE_REST;
                            amp_sd       <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            state        <= GAP;
                            gcnt         <= '0;
                            phase        <= 1'b0;
                            playing_note <= NOTE_REST;
                        end
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                GAP: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt <= '0;
                        if (req_valid) begin
                            state        <= TONE;
                            half         <= req_half;
                            cnt          <= '0;
                            phase        <= 1'b1;
                            cur_oct      <= req_oct;
                            playing_note <= req_note;
                        end else begin
                            state  <= SILENT;
                            amp_sd <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                default: begin
                    state        <= SILENT;
                    cnt          <= '0;
                    gcnt         <= '0;
                    phase        <= 1'b0;
                    playing_note <= NOTE_REST;
                    amp_sd       <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.speaker      = phase;
    assign bus.amp_sd       = amp_sd;
    assign bus.playing_note = playing_note;
    assign bus.busy         = busy;

endmodule
